reg_writeback: RTL and testbench

Write-side front end for the processor's register file. It merges single-cycle ALU results and variable-latency load results into the file's single write port, `wrData`/`wrNum`/`regWrite`. Load results are buffered in a small FIFO with a valid/ready handshake. A younger ALU write supersedes any buffered load to the same register. A per-register pending mask lets decode stall on outstanding loads.

---
 rtl/reg_writeback.sv | 150 +++++++++++++++
 tb/tb_reg_writeback.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: write-side front end for the register file.
// Merges single-cycle ALU results and buffered load results onto the single
// register-file write port. The ALU always has priority. A buffered load is
// "killed" when a younger ALU write targets the same register. A killed load
// stays in the buffer and is drained one per cycle without being written.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   aluValid/aluNum/aluData       ALU result, always accepted
//   memValid/memReady             load-result handshake
//   memNum/memData                load destination and data
//   wrData/wrNum/regWrite         registered register-file write port
//   pendingMask                   per-register flag for live buffered loads
//   fifoCount                     buffer occupancy, counting live and dead entries
module reg_writeback #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            aluValid,
    input  logic [REG_NUM_WIDTH-1:0]        aluNum,
    input  logic [DATA_WIDTH-1:0]           aluData,
    input  logic                            memValid,
    output logic                            memReady,
    input  logic [REG_NUM_WIDTH-1:0]        memNum,
    input  logic [DATA_WIDTH-1:0]           memData,
    output logic [DATA_WIDTH-1:0]           wrData,
    output logic [REG_NUM_WIDTH-1:0]        wrNum,
    output logic                            regWrite,
    output logic [(1<<REG_NUM_WIDTH)-1:0]   pendingMask,
    output logic [$clog2(FIFO_DEPTH):0]     fifoCount
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [REG_NUM_WIDTH-1:0] num_q  [FIFO_DEPTH];
    logic [REG_NUM_WIDTH-1:0] num_d  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    live_q, live_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [REG_NUM_WIDTH-1:0] wr_num_q, wr_num_d;
    logic                     reg_write_q, reg_write_d;

    logic alu_hit, fifo_empty, head_live, pop_live, pop_dead, pop;
    logic accept, push;

    assign memReady  = !rst && (count_q != FULL_CNT);
    assign fifoCount = count_q;
    assign wrData    = wr_data_q;
    assign wrNum     = wr_num_q;
    assign regWrite  = reg_write_q;

    always_comb begin
        alu_hit    = aluValid && (aluNum != '0);
        fifo_empty = (count_q == '0);
        head_live  = !fifo_empty && live_q[rd_ptr_q];
        // A dead head leaves regardless of ALU traffic; a live head waits for an idle ALU.
        pop_dead   = !fifo_empty && !live_q[rd_ptr_q];
        pop_live   = head_live && !alu_hit;
        pop        = pop_live || pop_dead;
        accept     = memValid && memReady;
        // r0 loads complete the handshake but never occupy an entry.
        push       = accept && (memNum != '0);
    end

    always_comb begin
        num_d  = num_q;
        data_d = data_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            live_d[i] = live_q[i] && !(alu_hit && (num_q[i] == aluNum));
        end
        // Clearing live on pop keeps free slots out of pendingMask.
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            num_d[wr_ptr_q]  = memNum;
            data_d[wr_ptr_q] = memData;
            live_d[wr_ptr_q] = !(alu_hit && (memNum == aluNum));
        end

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        wr_data_d   = wr_data_q;
        wr_num_d    = wr_num_q;
        reg_write_d = 1'b0;
        if (alu_hit) begin
            wr_data_d   = aluData;
            wr_num_d    = aluNum;
            reg_write_d = 1'b1;
        end else if (pop_live) begin
            wr_data_d   = data_q[rd_ptr_q];
            wr_num_d    = num_q[rd_ptr_q];
            reg_write_d = 1'b1;
        end
    end

    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_q[i]) begin
                pendingMask[num_q[i]] = 1'b1;
            end
        end
        pendingMask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                num_q[i]  <= '0;
                data_q[i] <= '0;
            end
            live_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wr_data_q   <= '0;
            wr_num_q    <= '0;
            reg_write_q <= 1'b0;
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                num_q[i]  <= num_d[i];
                data_q[i] <= data_d[i];
            end
            live_q      <= live_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wr_data_q   <= wr_data_d;
            wr_num_q    <= wr_num_d;
            reg_write_q <= reg_write_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback. Inputs are driven and outputs sampled on
// the falling edge, so each check sees the state after the preceding posedge.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid;
    logic [2:0]  aluNum;
    logic [31:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [2:0]  memNum;
    logic [31:0] memData;
    logic [31:0] wrData;
    logic [2:0]  wrNum;
    logic        regWrite;
    logic [7:0]  pendingMask;
    logic [2:0]  fifoCount;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_writeback #(
        .DATA_WIDTH(32),
        .REG_NUM_WIDTH(3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .aluValid(aluValid),
        .aluNum(aluNum),
        .aluData(aluData),
        .memValid(memValid),
        .memReady(memReady),
        .memNum(memNum),
        .memData(memData),
        .wrData(wrData),
        .wrNum(wrNum),
        .regWrite(regWrite),
        .pendingMask(pendingMask),
        .fifoCount(fifoCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input logic w, input logic [2:0] n, input logic [31:0] d);
        chk({tag, ".regWrite"}, {31'b0, regWrite}, {31'b0, w});
        chk({tag, ".wrNum"}, {29'b0, wrNum}, {29'b0, n});
        chk({tag, ".wrData"}, wrData, d);
    endtask

    task automatic chk_fifo(input string tag, input logic [2:0] cnt, input logic [7:0] mask);
        chk({tag, ".fifoCount"}, {29'b0, fifoCount}, {29'b0, cnt});
        chk({tag, ".pendingMask"}, {24'b0, pendingMask}, {24'b0, mask});
    endtask

    initial begin
        rst = 1'b1; aluValid = 1'b0; aluNum = '0; aluData = '0;
        memValid = 1'b0; memNum = '0; memData = '0;

        // reset
        step(); step();
        chk("rst.memReady", {31'b0, memReady}, 32'd0);
        chk_wr("rst", 1'b0, 3'd0, 32'h0);
        chk_fifo("rst", 3'd0, 8'h00);
        rst = 1'b0;
        #1 chk("rst_rel.memReady", {31'b0, memReady}, 32'd1);

        // single ALU write
        aluValid = 1'b1; aluNum = 3'd3; aluData = 32'h1234;
        step();
        chk_wr("alu1", 1'b1, 3'd3, 32'h1234);
        aluValid = 1'b0;
        step();
        chk_wr("alu1_idle", 1'b0, 3'd3, 32'h1234);

        // single load, ALU idle: two-cycle latency
        memValid = 1'b1; memNum = 3'd5; memData = 32'hAA;
        step();
        chk_fifo("ld5_T1", 3'd1, 8'h20);
        chk("ld5_T1.regWrite", {31'b0, regWrite}, 32'd0);
        memValid = 1'b0;
        step();
        chk_wr("ld5_T2", 1'b1, 3'd5, 32'hAA);
        chk_fifo("ld5_T2", 3'd0, 8'h00);
        step();
        chk("ld5_T3.regWrite", {31'b0, regWrite}, 32'd0);

        // fill buffer while ALU busy on r6, then drain in order
        aluValid = 1'b1; aluNum = 3'd6; aluData = 32'h66;
        for (int i = 1; i <= 4; i++) begin
            memValid = 1'b1; memNum = 3'(i); memData = 32'h10 + 32'(i);
            step();
        end
        chk_fifo("fill", 3'd4, 8'h1E);
        chk("fill.memReady", {31'b0, memReady}, 32'd0);
        chk_wr("fill_alu", 1'b1, 3'd6, 32'h66);
        memNum = 3'd7; memData = 32'h77;
        step(); step();
        chk("full_hold.fifoCount", {29'b0, fifoCount}, 32'd4);
        chk("full_hold.memReady", {31'b0, memReady}, 32'd0);
        aluValid = 1'b0;
        step();
        chk_wr("drain1", 1'b1, 3'd1, 32'h11);
        chk("drain1.fifoCount", {29'b0, fifoCount}, 32'd3);
        chk("drain1.memReady", {31'b0, memReady}, 32'd1);
        step();
        chk_wr("drain2", 1'b1, 3'd2, 32'h12);
        chk_fifo("drain2", 3'd3, 8'h98);
        memValid = 1'b0;
        step();
        chk_wr("drain3", 1'b1, 3'd3, 32'h13);
        step();
        chk_wr("drain4", 1'b1, 3'd4, 32'h14);
        step();
        chk_wr("drain5", 1'b1, 3'd7, 32'h77);
        chk_fifo("drain5", 3'd0, 8'h00);
        step();
        chk("drained.regWrite", {31'b0, regWrite}, 32'd0);

        // buffered load killed by younger ALU write
        memValid = 1'b1; memNum = 3'd2; memData = 32'h55;
        step();
        chk_fifo("kill_ld", 3'd1, 8'h04);
        memValid = 1'b0;
        aluValid = 1'b1; aluNum = 3'd2; aluData = 32'h77;
        step();
        chk_wr("kill_alu", 1'b1, 3'd2, 32'h77);
        chk_fifo("kill_alu", 3'd1, 8'h00);
        aluValid = 1'b0;
        step();
        chk_wr("kill_drop", 1'b0, 3'd2, 32'h77);
        chk_fifo("kill_drop", 3'd0, 8'h00);

        // r0 from both sources is dropped
        aluValid = 1'b1; aluNum = 3'd0; aluData = 32'hFF;
        memValid = 1'b1; memNum = 3'd0; memData = 32'hEE;
        #1 chk("r0.memReady", {31'b0, memReady}, 32'd1);
        step();
        chk_wr("r0", 1'b0, 3'd2, 32'h77);
        chk_fifo("r0", 3'd0, 8'h00);
        aluValid = 1'b0; memValid = 1'b0;

        // same-cycle ALU and load to one register: load enqueued dead
        aluValid = 1'b1; aluNum = 3'd4; aluData = 32'h44;
        memValid = 1'b1; memNum = 3'd4; memData = 32'h99;
        step();
        chk_wr("same4", 1'b1, 3'd4, 32'h44);
        chk_fifo("same4", 3'd1, 8'h00);
        aluValid = 1'b0; memValid = 1'b0;
        step();
        chk_wr("same4_drop", 1'b0, 3'd4, 32'h44);
        chk("same4_drop.fifoCount", {29'b0, fifoCount}, 32'd0);

        // reset mid-operation flushes buffered loads
        aluValid = 1'b1; aluNum = 3'd6; aluData = 32'h66;
        memValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            memNum = 3'(2 * i + 1); memData = 32'h30 + 32'(i);
            step();
        end
        chk_fifo("pre_rst", 3'd3, 8'h2A);
        rst = 1'b1; aluValid = 1'b0; memValid = 1'b0;
        #1 chk("mid_rst.memReady", {31'b0, memReady}, 32'd0);
        step();
        chk_fifo("post_rst", 3'd0, 8'h00);
        chk_wr("post_rst", 1'b0, 3'd0, 32'h0);
        rst = 1'b0;
        #1 chk("post_rst.memReady", {31'b0, memReady}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle.regWrite", {31'b0, regWrite}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
